// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with a master-to-slave multiplexer.
// Ownership is always parked on one master. It passes on only when the owner releases its request.
module bus_arbiter (
    input  logic        clk,
    input  logic        reset_,
    input  logic        M0Req_,
    input  logic        M1Req_,
    input  logic        M2Req_,
    input  logic        M3Req_,
    output logic        M0Grnt_,
    output logic        M1Grnt_,
    output logic        M2Grnt_,
    output logic        M3Grnt_,
    input  logic [29:0] M0Addr,
    input  logic [29:0] M1Addr,
    input  logic [29:0] M2Addr,
    input  logic [29:0] M3Addr,
    input  logic        M0As_,
    input  logic        M1As_,
    input  logic        M2As_,
    input  logic        M3As_,
    input  logic        M0RW,
    input  logic        M1RW,
    input  logic        M2RW,
    input  logic        M3RW,
    input  logic [31:0] M0WrData,
    input  logic [31:0] M1WrData,
    input  logic [31:0] M2WrData,
    input  logic [31:0] M3WrData,
    output logic [29:0] SlvAddr,
    output logic        SlvAs_,
    output logic        SlvRW,
    output logic [31:0] SlvWrData
);

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        OWN_M0 = 2'd0,
        OWN_M1 = 2'd1,
        OWN_M2 = 2'd2,
        OWN_M3 = 2'd3
    } owner_t;

    owner_t      owner;
    owner_t      owner_nxt;
    logic [3:0]  req_n;
    logic [1:0]  cand;
    logic        found;

    assign req_n = {M3Req_, M2Req_, M1Req_, M0Req_};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner <= OWN_M0;
        end else begin
            owner <= owner_nxt;
        end
    end

    // Search starts one past the owner, so the first hit is the rotating-priority winner.
    always_comb begin
        owner_nxt = owner;
        cand      = '0;
        found     = 1'b0;
        if (req_n[owner] == DISABLE_) begin
            for (int unsigned i = 1; i < 4; i++) begin
                cand = owner + 2'(i);
                if (!found && req_n[cand] == ENABLE_) begin
                    owner_nxt = owner_t'(cand);
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        M0Grnt_ = (owner == OWN_M0) ? ENABLE_ : DISABLE_;
        M1Grnt_ = (owner == OWN_M1) ? ENABLE_ : DISABLE_;
        M2Grnt_ = (owner == OWN_M2) ? ENABLE_ : DISABLE_;
        M3Grnt_ = (owner == OWN_M3) ? ENABLE_ : DISABLE_;
    end

    always_comb begin
        SlvAddr   = M0Addr;
        SlvAs_    = M0As_;
        SlvRW     = M0RW;
        SlvWrData = M0WrData;
        case (owner)
            OWN_M0: begin
                SlvAddr   = M0Addr;
                SlvAs_    = M0As_;
                SlvRW     = M0RW;
                SlvWrData = M0WrData;
            end
            OWN_M1: begin
                SlvAddr   = M1Addr;
                SlvAs_    = M1As_;
                SlvRW     = M1RW;
                SlvWrData = M1WrData;
            end
            OWN_M2: begin
                SlvAddr   = M2Addr;
                SlvAs_    = M2As_;
                SlvRW     = M2RW;
                SlvWrData = M2WrData;
            end
            OWN_M3: begin
                SlvAddr   = M3Addr;
                SlvAs_    = M3As_;
                SlvRW     = M3RW;
                SlvWrData = M3WrData;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed corner sequences, a request/owner table,
// and randomized traffic compared against a rotating-priority reference model.
module tb_bus_arbiter;

    localparam logic WRITE = 1'b0;

    logic        clk = 1'b0;
    logic        reset_;
    logic [3:0]  req_n;
    logic [3:0]  as_n;
    logic [3:0]  rw;
    logic [29:0] addr  [4];
    logic [31:0] wdata [4];
    logic [3:0]  grnt_n;
    logic [29:0] slv_addr;
    logic        slv_as_n;
    logic        slv_rw;
    logic [31:0] slv_wdata;

    int passed = 0;
    int total  = 0;
    int ref_owner;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk       (clk),
        .reset_    (reset_),
        .M0Req_    (req_n[0]),
        .M1Req_    (req_n[1]),
        .M2Req_    (req_n[2]),
        .M3Req_    (req_n[3]),
        .M0Grnt_   (grnt_n[0]),
        .M1Grnt_   (grnt_n[1]),
        .M2Grnt_   (grnt_n[2]),
        .M3Grnt_   (grnt_n[3]),
        .M0Addr    (addr[0]),
        .M1Addr    (addr[1]),
        .M2Addr    (addr[2]),
        .M3Addr    (addr[3]),
        .M0As_     (as_n[0]),
        .M1As_     (as_n[1]),
        .M2As_     (as_n[2]),
        .M3As_     (as_n[3]),
        .M0RW      (rw[0]),
        .M1RW      (rw[1]),
        .M2RW      (rw[2]),
        .M3RW      (rw[3]),
        .M0WrData  (wdata[0]),
        .M1WrData  (wdata[1]),
        .M2WrData  (wdata[2]),
        .M3WrData  (wdata[3]),
        .SlvAddr   (slv_addr),
        .SlvAs_    (slv_as_n),
        .SlvRW     (slv_rw),
        .SlvWrData (slv_wdata)
    );

    // Reference: owner keeps the bus while requesting; otherwise the nearest requester after it wins.
    function automatic int rr_next(int cur, logic [3:0] r);
        if (!r[cur]) return cur;
        for (int k = 1; k < 4; k++) begin
            if (!r[(cur + k) % 4]) return (cur + k) % 4;
        end
        return cur;
    endfunction

    always @(posedge clk or negedge reset_) begin
        if (!reset_) ref_owner <= 0;
        else         ref_owner <= rr_next(ref_owner, req_n);
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_owner(string name, int own);
        logic [3:0] eg;
        eg = 4'hF;
        eg[own] = 1'b0;
        check({name, " grant"}, 64'(grnt_n), 64'(eg));
        check({name, " slv_ctl"}, 64'({slv_addr, slv_as_n, slv_rw}),
              64'({addr[own], as_n[own], rw[own]}));
        check({name, " slv_wdata"}, 64'(slv_wdata), 64'(wdata[own]));
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #3;
    endtask

    task automatic idle_inputs();
        req_n = 4'hF;
        as_n  = 4'hF;
        rw    = 4'hF;
        for (int i = 0; i < 4; i++) begin
            addr[i]  = 30'(32'h0100_0000 * (i + 1) + i);
            wdata[i] = 32'hA000_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        #2;
        reset_ = 1'b0;
        #1;
        req_n  = 4'hF;
        #1;
        reset_ = 1'b1;
        edge_settle();
    endtask

    typedef struct {
        logic [3:0] req;
        int         owner;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{4'b1110, 0};
        tbl[1]  = '{4'b1101, 1};
        tbl[2]  = '{4'b1100, 1};
        tbl[3]  = '{4'b0011, 2};
        tbl[4]  = '{4'b0010, 2};
        tbl[5]  = '{4'b0110, 3};
        tbl[6]  = '{4'b1110, 0};
        tbl[7]  = '{4'b1111, 0};
        tbl[8]  = '{4'b0111, 3};
        tbl[9]  = '{4'b1111, 3};
        tbl[10] = '{4'b1010, 0};
        tbl[11] = '{4'b1011, 2};
        tbl[12] = '{4'b1111, 2};
        tbl[13] = '{4'b1101, 1};
        tbl[14] = '{4'b0000, 1};

        idle_inputs();
        reset_ = 1'b0;
        #12;
        check_owner("reset", 0);
        reset_ = 1'b1;
        edge_settle();

        // Drive owner to 2, then assert reset mid-cycle
        req_n = 4'b1011;
        edge_settle();
        check_owner("to_owner2", 2);
        addr[0] = 30'h1234;
        reset_  = 1'b0;
        #1;
        check("async_rst M0Grnt_", 64'(grnt_n[0]), 64'(0));
        check("async_rst M2Grnt_", 64'(grnt_n[2]), 64'(1));
        check("async_rst SlvAddr", 64'(slv_addr), 64'(30'h1234));
        req_n = 4'hF;
        #1;
        reset_ = 1'b1;
        edge_settle();

        // Owner request: zero added latency, held for 10 cycles despite M1 requesting
        req_n    = 4'b1100;
        as_n[0]  = 1'b0;
        addr[0]  = 30'h0100;
        rw[0]    = WRITE;
        wdata[0] = 32'hDEADBEEF;
        #1;
        check("owner_req SlvAddr", 64'(slv_addr), 64'(30'h0100));
        check("owner_req SlvAs_", 64'(slv_as_n), 64'(0));
        check("owner_req SlvRW", 64'(slv_rw), 64'(WRITE));
        check("owner_req SlvWrData", 64'(slv_wdata), 64'(32'hDEADBEEF));
        for (int c = 0; c < 10; c++) edge_settle();
        check_owner("owner_hold10", 0);

        // Non-owner request: grant one cycle later, never combinationally
        req_n = 4'b1101;
        as_n  = 4'b1101;
        #1;
        check_owner("nonowner_same_cycle", 0);
        edge_settle();
        check_owner("nonowner_k1", 1);
        check("nonowner SlvAddr", 64'(slv_addr), 64'(addr[1]));

        // Round robin from owner 1 with M0, M2, M3 all requesting
        req_n = 4'b0000;
        edge_settle();
        check_owner("rr_hold1", 1);
        req_n = 4'b0010;
        #1;
        check_owner("rr_rel1_same", 1);
        edge_settle();
        check_owner("rr_to2", 2);
        req_n = 4'b0110;
        edge_settle();
        check_owner("rr_to3", 3);
        req_n = 4'b1110;
        edge_settle();
        check_owner("rr_to0", 0);

        // No preemption: owner 3 holds for 20 cycles against all others
        req_n = 4'b0111;
        edge_settle();
        check_owner("np_to3", 3);
        req_n = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            edge_settle();
            check("np_hold M3Grnt_", 64'(grnt_n[3]), 64'(0));
        end
        req_n = 4'b1000;
        #1;
        check_owner("np_rel_same", 3);
        edge_settle();
        check("np_handover M0Grnt_", 64'(grnt_n[0]), 64'(0));
        check_owner("np_handover", 0);

        // Non-owner strobe isolation
        req_n   = 4'b1110;
        as_n    = 4'b1011;
        addr[2] = 30'h3FFF;
        addr[0] = 30'h0555;
        edge_settle();
        check("iso SlvAs_", 64'(slv_as_n), 64'(1));
        check("iso SlvAddr", 64'(slv_addr), 64'(30'h0555));

        // Table-driven owner sequence from a fresh reset
        idle_inputs();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            req_n = tbl[i].req;
            edge_settle();
            check_owner($sformatf("tbl[%0d]", i), tbl[i].owner);
        end

        // Randomized traffic vs reference model
        idle_inputs();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 4; m++) begin
                req_n[m]  = ($urandom_range(0, 2) != 0);
                as_n[m]   = 1'($urandom);
                rw[m]     = 1'($urandom);
                addr[m]   = 30'($urandom);
                wdata[m]  = $urandom;
            end
            if ($urandom_range(0, 199) == 0) begin
                reset_ = 1'b0;
                #1;
                check_owner("rand_async_rst", 0);
                reset_ = 1'b1;
            end
            edge_settle();
            check_owner("rand", ref_owner);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
